// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a loadable N-input truth table and streams
// the selected rows (all, minterms or maxterms) over a valid/ready handshake.
module truth_table_sweeper #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [(1<<N)-1:0]    func_in,
   input  logic [1:0]           mode,
   input  logic                 start,
   input  logic                 row_ready,
   output logic                 row_valid,
   output logic [N-1:0]         row_in,
   output logic                 row_out,
   output logic                 busy,
   output logic                 done,
   output logic [N:0]           ones_count
);

   // state  | meaning
   // S_IDLE | waiting; load/start honoured here only
   // S_SCAN | presenting or skipping the row at idx
   // S_DONE | one-cycle end-of-sweep pulse
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam int         ROWS = 1 << N;
   localparam logic [N:0] LAST = (N+1)'(ROWS - 1);

   state_t            state, state_n;
   logic [ROWS-1:0]   table_r, table_n;
   logic [N:0]        idx, idx_n;
   logic [1:0]        mode_r, mode_n;
   logic [N:0]        ones_r, ones_n;

   logic f_cur;
   logic sel;
   logic advance;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         table_r <= '0;
         idx     <= '0;
         mode_r  <= '0;
         ones_r  <= '0;
      end else begin
         state   <= state_n;
         table_r <= table_n;
         idx     <= idx_n;
         mode_r  <= mode_n;
         ones_r  <= ones_n;
      end
   end

   always_comb begin
      state_n = state;
      table_n = table_r;
      idx_n   = idx;
      mode_n  = mode_r;
      ones_n  = ones_r;

      f_cur = table_r[idx[N-1:0]];
      // mode 3 is reserved and falls through to "all rows"
      case (mode_r)
         2'd1:    sel = f_cur;
         2'd2:    sel = ~f_cur;
         default: sel = 1'b1;
      endcase
      advance = (state == S_SCAN) && (!sel || row_ready);

      case (state)
         S_IDLE: begin
            if (load) table_n = func_in;
            if (start) begin
               idx_n   = '0;
               ones_n  = '0;
               mode_n  = mode;
               state_n = S_SCAN;
            end
         end
         S_SCAN: begin
            if (advance) begin
               ones_n = ones_r + {{N{1'b0}}, f_cur};
               if (idx == LAST) state_n = S_DONE;
               else             idx_n   = idx + (N+1)'(1);
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Row fields are zeroed when nothing is presented so idle outputs read 0.
   assign row_valid  = (state == S_SCAN) && sel;
   assign row_in     = row_valid ? idx[N-1:0] : '0;
   assign row_out    = row_valid & f_cur;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign ones_count = ones_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: sweeps push expected rows, an independent monitor pops and
// compares whatever the DUT presents.
module tb_truth_table_sweeper;

   logic       clk = 0;
   logic       reset = 1;
   logic       load = 0, start = 0, row_ready = 1;
   logic [7:0] func_in = '0;
   logic [1:0] mode = '0;
   logic       row_valid, row_out, busy, done;
   logic [2:0] row_in;
   logic [3:0] ones_count;

   logic       load1 = 0, start1 = 0, ready1 = 1;
   logic [1:0] func1 = '0;
   logic [1:0] mode1 = '0;
   logic       valid1, rout1, busy1, done1;
   logic [0:0] rin1;
   logic [1:0] ones1;

   truth_table_sweeper #(.N(3)) dut (
      .clk(clk), .reset(reset), .load(load), .func_in(func_in), .mode(mode),
      .start(start), .row_ready(row_ready), .row_valid(row_valid),
      .row_in(row_in), .row_out(row_out), .busy(busy), .done(done),
      .ones_count(ones_count));

   truth_table_sweeper #(.N(1)) dut1 (
      .clk(clk), .reset(reset), .load(load1), .func_in(func1), .mode(mode1),
      .start(start1), .row_ready(ready1), .row_valid(valid1),
      .row_in(rin1), .row_out(rout1), .busy(busy1), .done(done1),
      .ones_count(ones1));

   always #5 clk = ~clk;

   typedef struct {int ri; int ro; int off;} exp_t;
   exp_t q[$];

   int  n_checks = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  t0 = 0;
   int  stalls = 0;
   bit  tog = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (tog) row_ready = ~row_ready;
      else     row_ready = 1'b1;
   end

   // monitor: compare every presented row against the head of the queue
   initial forever begin
      @(negedge clk);
      if (row_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_row", int'(row_in), -1);
         end else begin
            chk("row_in", int'(row_in), q[0].ri);
            chk("row_out", int'(row_out), q[0].ro);
            if (q[0].off > 0) chk("row_cycle", cyc - t0 + 1, q[0].off);
            if (row_ready) void'(q.pop_front());
            else           stalls++;
         end
      end
   end

   task automatic load_table(input logic [7:0] tbl);
      @(posedge clk); #1;
      load = 1; func_in = tbl;
      @(posedge clk); #1;
      load = 0;
   endtask

   // disturb: 0 none, 1 load/start pulse mid-sweep, 2 reset at row 4
   task automatic run_sweep(input logic [7:0] tbl, input logic do_load,
                            input logic [1:0] md, input bit tg,
                            input int disturb, input int exp_ones);
      int off;
      bit seen;
      bit aborted;
      off = 0; seen = 0; aborted = 0;
      q.delete();
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         bit f;
         f = tbl[i];
         if (md == 2'd0 || md == 2'd3 || (md == 2'd1 && f) || (md == 2'd2 && !f))
            q.push_back('{i, int'(f), tg ? 0 : i + 1});
      end
      @(posedge clk); #1;
      start = 1; mode = md; load = do_load; func_in = tbl;
      @(posedge clk); #1;
      t0 = cyc; start = 0; load = 0;
      tog = tg;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         off = cyc - t0 + 1;
         if (off == 1) chk("busy_on", int'(busy), 1);
         if (disturb == 1 && off == 3) begin
            load = 1; func_in = 8'hFF; start = 1; mode = 2'd2;
         end
         if (disturb == 1 && off == 4) begin
            load = 0; start = 0;
         end
         if (disturb == 2 && off == 5) reset = 1;
         if (disturb == 2 && off == 6) begin
            chk("abort_valid", int'(row_valid), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_ones", int'(ones_count), 0);
            reset = 0;
            aborted = 1;
            break;
         end
         if (done) begin
            seen = 1;
            break;
         end
      end
      tog = 0;
      if (aborted) begin
         q.delete();
      end else begin
         chk("done_seen", int'(seen), 1);
         chk("done_cycle", off, 9 + stalls);
         chk("ones_count", int'(ones_count), exp_ones);
         chk("rows_left", q.size(), 0);
         @(negedge clk);
         chk("done_pulse_end", int'(done), 0);
         chk("busy_off", int'(busy), 0);
         chk("ones_hold", int'(ones_count), exp_ones);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(row_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ones", int'(ones_count), 0);
      chk("rst_row_in", int'(row_in), 0);
      chk("rst_valid1", int'(valid1), 0);
      reset = 0;

      load_table(8'hDC);
      run_sweep(8'hDC, 1'b0, 2'd0, 1'b0, 0, 5);
      run_sweep(8'hDC, 1'b0, 2'd1, 1'b0, 0, 5);
      run_sweep(8'hDC, 1'b0, 2'd2, 1'b1, 0, 5);
      chk("mode2_stalled", int'(stalls > 0), 1);
      run_sweep(8'hDC, 1'b0, 2'd0, 1'b0, 1, 5);
      run_sweep(8'hDC, 1'b0, 2'd3, 1'b0, 0, 5);
      run_sweep(8'hFF, 1'b1, 2'd2, 1'b0, 0, 8);
      run_sweep(8'hFF, 1'b0, 2'd0, 1'b0, 2, 0);
      run_sweep(8'h00, 1'b0, 2'd0, 1'b0, 0, 0);

      @(posedge clk); #1;
      load1 = 1; func1 = 2'b10; mode1 = 2'd0; start1 = 1;
      @(posedge clk); #1;
      load1 = 0; start1 = 0;
      @(negedge clk);
      chk("n1_valid0", int'(valid1), 1);
      chk("n1_in0", int'(rin1), 0);
      chk("n1_out0", int'(rout1), 0);
      @(negedge clk);
      chk("n1_valid1", int'(valid1), 1);
      chk("n1_in1", int'(rin1), 1);
      chk("n1_out1", int'(rout1), 1);
      @(negedge clk);
      chk("n1_done", int'(done1), 1);
      chk("n1_ones", int'(ones1), 1);
      @(negedge clk);
      chk("n1_idle", int'(busy1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential evaluator for an arbitrary N-input Boolean function held as a loadable truth-table register. On `start` it walks every input combination 0..2^N-1 in ascending order and streams each selected row (inputs plus function value) out over a valid/ready handshake. Mode selects all rows, minterms only, or maxterms only. It also counts the function's ones, and is the self-checking table generator used alongside the combinational expression modules in the guide exercises.

## Interface
- `N`, default 3: number of function inputs; legal 1..8; ROWS = 2^N.
- `clk`  input  1: single clock; all state updates on rising edge.
- `reset`  input  1: synchronous, active-high; sampled on `clk` rising edge.
- `load`  input  1: when high in IDLE, capture `func_in` into the truth-table register.
- `func_in`  input  ROWS: truth table; bit i = f(input vector i), MSB of the vector = first variable.
- `mode`  input  2: 0 = all rows, 1 = minterms only (f=1), 2 = maxterms only (f=0), 3 = reserved, behaves as 0; sampled on `start`.
- `start`  input  1: when high in IDLE, begin a sweep.
- `row_ready`  input  1: consumer accepts the presented row.
- `row_valid`  output  1: a selected row is presented.
- `row_in`  output  N: current input vector (row index).
- `row_out`  output  1: f(row_in).
- `busy`  output  1: high in SCAN and DONE.
- `done`  output  1: one-cycle pulse at sweep end.
- `ones_count`  output  N+1: number of rows with f=1 processed in the current or last sweep.

## Operation
- States: IDLE, SCAN, DONE. Reset -> IDLE; truth-table register = 0, index = 0, mode register = 0, `ones_count` = 0; all outputs 0.
- IDLE:
  - `load` captures `func_in`. `load` and `start` in the same cycle: the load is applied first, and the sweep uses the new table.
  - `start` clears the index and `ones_count`, latches `mode`, and goes to SCAN.
- SCAN, per index:
  - A row is selected if mode 0/3, or mode 1 with f=1, or mode 2 with f=0.
  - Selected row: `row_valid` = 1, `row_in` = index, `row_out` = f[index]. All three are held stable until `row_valid && row_ready` on a rising edge.
  - Unselected row: skipped in exactly one cycle with `row_valid` = 0.
  - A row is processed on acceptance or skip. On processing, `ones_count` increments if f[index] = 1, regardless of mode.
  - If index = ROWS-1, go to DONE. Otherwise index + 1.
- DONE: `done` = 1 for one cycle, then IDLE. `ones_count` holds its final value until the next `start` or `reset`.
- Index arithmetic is N+1 bits internally, so the last-row compare is not defeated by wrap-around. Index never exceeds ROWS-1.
- `load` and `start` while `busy` are ignored; the table and mode stay frozen for the whole sweep.
- `row_ready` while `row_valid` = 0 has no effect.
- `reset` mid-sweep aborts at once: next cycle is IDLE with all outputs 0 and the table cleared.

## Timing
- Outputs depend only on registered state; there is no combinational input-to-output path.
- `start` sampled at edge T0 -> first row presented in cycle T0+1.
- With `row_ready` held high, each index costs exactly 1 cycle (accepted or skipped). Rows occupy T0+1..T0+ROWS, `done` is in T0+ROWS+1, and a new `start` is accepted from T0+ROWS+2.
- Each cycle a selected row waits for `row_ready` adds one cycle. Latency = ROWS + stall cycles + 1 to `done`.
- Mode 1 with an all-zero table (or mode 2 with all-ones): `row_valid` never asserts, `done` still pulses at T0+ROWS+1.

## Test plan
- N=3, load 8'hDC (f = (x+y)(y+z')), mode 0, ready=1 -> rows 000..111 with `row_out` 0,0,1,1,1,0,1,1 in cycles T0+1..T0+8; `done` at T0+9; `ones_count` = 5.
- Same table, mode 1, ready=1 -> `row_valid` only for `row_in` 2,3,4,6,7; `done` at T0+9; `ones_count` = 5.
- Same table, mode 2, ready toggling 1/0 every cycle -> rows 0,1,5 only, each held stable through stalls; `done` after 8 + stall cycles; `ones_count` = 5.
- `load` 8'hFF and a second `start` pulsed mid-sweep of 8'hDC -> both ignored; outputs match the 8'hDC sweep exactly; after `done`, `load` 8'hFF + mode 2 -> no valid rows, `done` at T0+9, `ones_count` = 8.
- `reset` asserted at row 4 of a sweep -> next cycle IDLE, `row_valid`/`busy`/`done` = 0, `ones_count` = 0; a subsequent `start` without `load` sweeps the all-zero table (`ones_count` = 0).
- N=1, table 2'b10, mode 0 -> rows (0,0),(1,1); `done` at T0+3; `ones_count` = 1.
